// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, instruction
// field positions and controller state encoding.
package alu_issue_ctrl_pkg;

  // ALU opcodes
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_INC  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_DEC  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NAND = 4'h7;
  localparam logic [3:0] OP_SHL1 = 4'h8;
  localparam logic [3:0] OP_SHL2 = 4'h9;
  localparam logic [3:0] OP_SHL3 = 4'hA;
  localparam logic [3:0] OP_SHL4 = 4'hB;
  localparam logic [3:0] OP_SHR1 = 4'hC;
  localparam logic [3:0] OP_SHR2 = 4'hD;
  localparam logic [3:0] OP_SHR3 = 4'hE;
  localparam logic [3:0] OP_SHR4 = 4'hF;

  // Instruction word layout: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2
  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 8;
  localparam int RS1_LSB = 4;
  localparam int RS2_LSB = 0;
  localparam int FLD_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_regfile.sv
// NREGS x WIDTH register file: one write port (write-back wins over the
// external preload), two operand read ports and a debug read port.
module alu_regfile #(
  parameter int WIDTH = 8,
  parameter int NREGS = 16,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_ext_we,
  input  logic [AW-1:0]    i_ext_addr,
  input  logic [WIDTH-1:0] i_ext_wdata,
  input  logic             i_wb_we,
  input  logic [AW-1:0]    i_wb_addr,
  input  logic [WIDTH-1:0] i_wb_data,
  input  logic [AW-1:0]    i_ra1,
  input  logic [AW-1:0]    i_ra2,
  input  logic [AW-1:0]    i_dbg_addr,
  output logic [WIDTH-1:0] o_rd1,
  output logic [WIDTH-1:0] o_rd2,
  output logic [WIDTH-1:0] o_dbg_data
);

  logic [WIDTH-1:0] r_mem [NREGS];

  // Synchronous clear on reset, otherwise a single prioritized write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (i_wb_we) begin
      r_mem[i_wb_addr] <= i_wb_data;
    end else if (i_ext_we) begin
      r_mem[i_ext_addr] <= i_ext_wdata;
    end
  end

  assign o_rd1      = r_mem[i_ra1];
  assign o_rd2      = r_mem[i_ra2];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Instruction-side driver for the 16-op ALU: accepts an instruction, issues
// registered operands to the external ALU, writes the result back and
// records the status flags. One instruction every 3 cycles.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [15:0]      instr,
  output logic             instr_ready,
  input  logic             ext_we,
  input  logic [3:0]       ext_addr,
  input  logic [WIDTH-1:0] ext_wdata,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             done,
  output logic             flag_zero,
  output logic             flag_overflow,
  input  logic [3:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  state_e           r_state, w_next;
  logic [3:0]       r_rd;
  logic             r_done;
  logic             w_accept, w_ext_we, w_wb_we;
  logic [3:0]       w_opc, w_rd, w_rs1, w_rs2;
  logic [WIDTH-1:0] w_rd1, w_rd2, w_op1, w_op2;

  assign w_opc = instr[OPC_LSB +: FLD_W];
  assign w_rd  = instr[RD_LSB  +: FLD_W];
  assign w_rs1 = instr[RS1_LSB +: FLD_W];
  assign w_rs2 = instr[RS2_LSB +: FLD_W];

  alu_regfile #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(4)) u_rf (
    .clk        (clk),
    .rst        (rst),
    .i_ext_we   (w_ext_we),
    .i_ext_addr (ext_addr),
    .i_ext_wdata(ext_wdata),
    .i_wb_we    (w_wb_we),
    .i_wb_addr  (r_rd),
    .i_wb_data  (alu_result),
    .i_ra1      (w_rs1),
    .i_ra2      (w_rs2),
    .i_dbg_addr (dbg_addr),
    .o_rd1      (w_rd1),
    .o_rd2      (w_rd2),
    .o_dbg_data (dbg_data)
  );

  // A preload landing on the same edge as the accept must be seen by the
  // issued operands, so forward it around the register file.
  assign w_op1 = (w_ext_we && (ext_addr == w_rs1)) ? ext_wdata : w_rd1;
  assign w_op2 = (w_ext_we && (ext_addr == w_rs2)) ? ext_wdata : w_rd2;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state, handshake and write strobes
  always_comb begin
    w_next      = r_state;
    instr_ready = 1'b0;
    w_accept    = 1'b0;
    w_ext_we    = 1'b0;
    w_wb_we     = 1'b0;
    case (r_state)
      IDLE: begin
        instr_ready = 1'b1;
        w_ext_we    = ext_we;
        if (instr_valid) begin
          w_accept = 1'b1;
          w_next   = ISSUE;
        end
      end
      ISSUE: begin
        w_wb_we = 1'b1;
        w_next  = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Issue registers, done pulse and status flags; all hold between ops
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_opcode    <= '0;
      alu_op1       <= '0;
      alu_op2       <= '0;
      r_rd          <= '0;
      r_done        <= 1'b0;
      flag_zero     <= 1'b0;
      flag_overflow <= 1'b0;
    end else begin
      r_done <= w_wb_we;
      if (w_accept) begin
        alu_opcode <= w_opc;
        alu_op1    <= w_op1;
        alu_op2    <= w_op2;
        r_rd       <= w_rd;
      end
      if (w_wb_we) begin
        flag_zero     <= alu_zero;
        flag_overflow <= alu_overflow;
      end
    end
  end

  assign done = r_done;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU and
// register-file model.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  logic        clk = 0, rst = 1, instr_valid = 0, ext_we = 0;
  logic [15:0] instr = '0;
  logic [3:0]  ext_addr = '0, dbg_addr = '0, alu_opcode;
  logic [7:0]  ext_wdata = '0, alu_op1, alu_op2, alu_result, dbg_data;
  logic        instr_ready, alu_zero, alu_overflow, done, flag_zero, flag_overflow;

  int checks = 0, errors = 0;
  logic [7:0] m_rf [16];

  alu_issue_ctrl #(.WIDTH(8), .NREGS(16)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .alu_opcode(alu_opcode), .alu_op1(alu_op1),
    .alu_op2(alu_op2), .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .done(done), .flag_zero(flag_zero),
    .flag_overflow(flag_overflow), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // ALU behaviour: returns {overflow, zero, result}
  function automatic logic [9:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic ov;
    ov = 1'b0;
    case (op)
      OP_ADD:  begin r = a + b; ov = (a[7] == b[7]) && (r[7] != a[7]); end
      OP_INC:  begin r = a + 8'd1; ov = (a == 8'h7F); end
      OP_SUB:  begin r = a - b; ov = (a[7] != b[7]) && (r[7] != a[7]); end
      OP_DEC:  begin r = a - 8'd1; ov = (a == 8'h80); end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_SHL1: r = a << 1;
      OP_SHL2: r = a << 2;
      OP_SHL3: r = a << 3;
      OP_SHL4: r = a << 4;
      OP_SHR1: r = a >> 1;
      OP_SHR2: r = a >> 2;
      OP_SHR3: r = a >> 3;
      default: r = a >> 4;
    endcase
    return {ov, (r == 8'h00), r};
  endfunction

  // Combinational ALU hanging off the controller outputs
  always_comb {alu_overflow, alu_zero, alu_result} = alu_ref(alu_opcode, alu_op1, alu_op2);

  task automatic preload(input logic [3:0] a, input logic [7:0] d);
    ext_we = 1; ext_addr = a; ext_wdata = d;
    @(posedge clk); #1;
    ext_we = 0;
    m_rf[a] = d;
  endtask

  // One full instruction; optional same-edge preload and optional junk
  // (ext write + instr_valid) driven while the controller is busy.
  task automatic run_instr(input logic [15:0] ins, input bit ext_en, input logic [3:0] ea,
                           input logic [7:0] ed, input bit busy, input string tag);
    logic [3:0] op, rd, rs1, rs2;
    logic [7:0] e1, e2;
    logic [9:0] ex;
    op = ins[15:12]; rd = ins[11:8]; rs1 = ins[7:4]; rs2 = ins[3:0];
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL %s ready_idle got %b exp 1", tag, instr_ready); end
    instr = ins; instr_valid = 1; ext_we = ext_en; ext_addr = ea; ext_wdata = ed;
    if (ext_en) m_rf[ea] = ed;
    e1 = m_rf[rs1]; e2 = m_rf[rs2]; ex = alu_ref(op, e1, e2);
    @(posedge clk); #1;
    instr_valid = 0; ext_we = 0; instr = 16'($urandom);
    if (busy) begin instr_valid = 1; ext_we = 1; ext_addr = 4'hE; ext_wdata = ~m_rf[14]; end
    checks++; if (alu_opcode !== op) begin errors++; $display("FAIL %s opcode got %h exp %h", tag, alu_opcode, op); end
    checks++; if (alu_op1 !== e1) begin errors++; $display("FAIL %s op1 got %h exp %h", tag, alu_op1, e1); end
    checks++; if (alu_op2 !== e2) begin errors++; $display("FAIL %s op2 got %h exp %h", tag, alu_op2, e2); end
    checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL %s ready_issue got %b exp 0", tag, instr_ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done_issue got %b exp 0", tag, done); end
    @(posedge clk); #1;
    m_rf[rd] = ex[7:0];
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s done_pulse got %b exp 1", tag, done); end
    checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL %s ready_done got %b exp 0", tag, instr_ready); end
    checks++; if (flag_zero !== ex[8]) begin errors++; $display("FAIL %s flag_zero got %b exp %b", tag, flag_zero, ex[8]); end
    checks++; if (flag_overflow !== ex[9]) begin errors++; $display("FAIL %s flag_ovf got %b exp %b", tag, flag_overflow, ex[9]); end
    dbg_addr = rd; #1;
    checks++; if (dbg_data !== m_rf[rd]) begin errors++; $display("FAIL %s wb_r%0h got %h exp %h", tag, rd, dbg_data, m_rf[rd]); end
    @(posedge clk); #1;
    instr_valid = 0; ext_we = 0;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done_clear got %b exp 0", tag, done); end
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL %s ready_back got %b exp 1", tag, instr_ready); end
    if (busy) begin
      dbg_addr = 4'hE; #1;
      checks++; if (dbg_data !== m_rf[14]) begin errors++; $display("FAIL %s busy_ext_rE got %h exp %h", tag, dbg_data, m_rf[14]); end
    end
  endtask

  task automatic check_rf_clear(input string tag);
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i); #1;
      checks++; if (dbg_data !== 8'h00) begin errors++; $display("FAIL %s r%0h got %h exp 00", tag, i, dbg_data); end
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1; rst = 0;
    for (int i = 0; i < 16; i++) m_rf[i] = 8'h00;
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset ready got %b exp 1", instr_ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done got %b exp 0", done); end
    checks++; if ({alu_opcode, alu_op1, alu_op2} !== 20'h0) begin errors++; $display("FAIL reset alu_out got %h exp 0", {alu_opcode, alu_op1, alu_op2}); end
    checks++; if ({flag_zero, flag_overflow} !== 2'b00) begin errors++; $display("FAIL reset flags got %b exp 00", {flag_zero, flag_overflow}); end
    check_rf_clear("reset");
  endtask

  task automatic test_directed();
    preload(4'h1, 8'h05); preload(4'h2, 8'h03);
    run_instr(16'h0312, 0, 0, 0, 0, "add");
    dbg_addr = 4'h3; #1;
    checks++; if ({dbg_data, flag_zero, flag_overflow} !== {8'h08, 2'b00}) begin errors++; $display("FAIL add_const got %h exp 020", {dbg_data, flag_zero, flag_overflow}); end
    preload(4'h1, 8'h7F); preload(4'h2, 8'h01);
    run_instr(16'h0412, 0, 0, 0, 0, "add_ovf");
    dbg_addr = 4'h4; #1;
    checks++; if ({dbg_data, flag_zero, flag_overflow} !== {8'h80, 2'b01}) begin errors++; $display("FAIL ovf_const got %h exp 201", {dbg_data, flag_zero, flag_overflow}); end
    preload(4'h5, 8'h2A); preload(4'h6, 8'h2A);
    run_instr(16'h2756, 0, 0, 0, 0, "sub_zero");
    dbg_addr = 4'h7; #1;
    checks++; if ({dbg_data, flag_zero, flag_overflow} !== {8'h00, 2'b10}) begin errors++; $display("FAIL zero_const got %h exp 002", {dbg_data, flag_zero, flag_overflow}); end
    preload(4'h8, 8'hF0);
    run_instr(16'hF980, 0, 0, 0, 0, "shr4");
    run_instr(16'h8A90, 0, 0, 0, 0, "shl1");
    dbg_addr = 4'h9; #1;
    checks++; if (dbg_data !== 8'h0F) begin errors++; $display("FAIL shr4_const got %h exp 0f", dbg_data); end
    dbg_addr = 4'hA; #1;
    checks++; if (dbg_data !== 8'h1E) begin errors++; $display("FAIL shl1_const got %h exp 1e", dbg_data); end
  endtask

  task automatic test_same_edge_ext();
    run_instr(16'h0C11, 1, 4'h1, 8'h11, 0, "bypass");
    dbg_addr = 4'hC; #1;
    checks++; if (dbg_data !== 8'h22) begin errors++; $display("FAIL bypass_const got %h exp 22", dbg_data); end
  endtask

  task automatic test_busy_ignored();
    preload(4'hE, 8'h3C);
    run_instr(16'h5312, 0, 0, 0, 1, "busy");
  endtask

  task automatic test_back_to_back();
    logic [9:0] ea, eb;
    int dcount;
    preload(4'h1, 8'h9A); preload(4'h2, 8'h47); preload(4'h3, 8'h5C);
    ea = alu_ref(OP_ADD, m_rf[1], m_rf[2]); m_rf[13] = ea[7:0];
    eb = alu_ref(OP_XOR, m_rf[3], m_rf[13]); m_rf[14] = eb[7:0];
    dcount = 0;
    instr = 16'h0D12; instr_valid = 1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (k == 0) instr = 16'h6E3D;
      if (k == 3) instr_valid = 0;
      if (done === 1'b1) dcount++;
      checks++; if (done !== (k == 1 || k == 4)) begin errors++; $display("FAIL b2b done@%0d got %b exp %b", k, done, (k == 1 || k == 4)); end
      checks++; if (instr_ready !== (k == 2 || k >= 5)) begin errors++; $display("FAIL b2b ready@%0d got %b exp %b", k, instr_ready, (k == 2 || k >= 5)); end
    end
    checks++; if (dcount != 2) begin errors++; $display("FAIL b2b done_count got %0d exp 2", dcount); end
    dbg_addr = 4'hD; #1;
    checks++; if (dbg_data !== m_rf[13]) begin errors++; $display("FAIL b2b rD got %h exp %h", dbg_data, m_rf[13]); end
    dbg_addr = 4'hE; #1;
    checks++; if (dbg_data !== m_rf[14]) begin errors++; $display("FAIL b2b rE got %h exp %h", dbg_data, m_rf[14]); end
  endtask

  task automatic test_reset_mid();
    preload(4'h1, 8'h21); preload(4'h2, 8'h42);
    instr = 16'h0B12; instr_valid = 1;
    @(posedge clk); #1;
    instr_valid = 0; rst = 1;
    checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL rstmid in_issue ready got %b exp 0", instr_ready); end
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 16; i++) m_rf[i] = 8'h00;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid done got %b exp 0", done); end
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rstmid ready got %b exp 1", instr_ready); end
    checks++; if ({alu_opcode, alu_op1, alu_op2, flag_zero, flag_overflow} !== 22'h0) begin errors++; $display("FAIL rstmid outs got %h exp 0", {alu_opcode, alu_op1, alu_op2, flag_zero, flag_overflow}); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid late_done got %b exp 0", done); end
    check_rf_clear("rstmid");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(2) == 0) preload(4'($urandom), 8'($urandom));
      run_instr(16'($urandom), ($urandom_range(3) == 0), 4'($urandom), 8'($urandom),
                ($urandom_range(4) == 0), "rand");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_same_edge_ext();
    test_busy_ignored();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
